// File: rtl/riscv_dmi_target.sv
// DMI target front-end: one DMI request at a time onto the debug-module
// register bus, with a grant timeout for a stalled backend.
module riscv_dmi_target #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmi_req_valid_i,
  output logic                  dmi_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmi_req_addr_i,
  input  logic [DATA_WIDTH-1:0] dmi_req_data_i,
  input  logic [1:0]            dmi_req_op_i,
  output logic                  dmi_resp_valid_o,
  input  logic                  dmi_resp_ready_i,
  output logic [DATA_WIDTH-1:0] dmi_resp_data_o,
  output logic [1:0]            dmi_resp_op_o,
  output logic                  reg_req_o,
  output logic                  reg_we_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  input  logic                  reg_gnt_i,
  input  logic                  reg_rvalid_i,
  input  logic [DATA_WIDTH-1:0] reg_rdata_i,
  input  logic                  reg_err_i
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLAST_INT = (TIMEOUT_CYCLES > 0) ?
                             TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TLAST = TW'(TLAST_INT);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_FAIL  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rop_q, rop_d;
  logic                  capture;
  logic [DATA_WIDTH-1:0] done_data;
  logic [1:0]            done_op;

  // Completion result, shared by the REQ fast path and WAIT.
  always_comb begin
    done_op   = reg_err_i ? ST_FAIL : ST_OK;
    done_data = '0;
    if (!reg_err_i && op_q == OP_READ) begin
      done_data = reg_rdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    rop_d   = rop_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dmi_req_valid_i) begin
          capture = 1'b1;
          timer_d = '0;
          rdata_d = '0;
          unique case (dmi_req_op_i)
            OP_NOP: begin
              state_d = RESP;
              rop_d   = ST_OK;
            end
            OP_RSVD: begin
              state_d = RESP;
              rop_d   = ST_FAIL;
            end
            default: state_d = REQ;
          endcase
        end
      end
      REQ: begin
        if (reg_gnt_i) begin
          if (reg_rvalid_i) begin
            state_d = RESP;
            rdata_d = done_data;
            rop_d   = done_op;
          end else begin
            state_d = WAIT;
          end
        end else if (TO_EN && timer_q == TLAST) begin
          state_d = RESP;
          rdata_d = '0;
          rop_d   = ST_FAIL;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT: begin
        if (reg_rvalid_i) begin
          state_d = RESP;
          rdata_d = done_data;
          rop_d   = done_op;
        end
      end
      RESP: begin
        if (dmi_resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= '0;
      rdata_q <= '0;
      rop_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      rop_q   <= rop_d;
      if (capture) begin
        addr_q <= dmi_req_addr_i;
        data_q <= dmi_req_data_i;
        op_q   <= dmi_req_op_i;
      end
    end
  end

  // Gating with rst_i makes handshakes drop the moment reset asserts.
  assign dmi_req_ready_o  = (state_q == IDLE) & ~rst_i;
  assign dmi_resp_valid_o = (state_q == RESP) & ~rst_i;
  assign dmi_resp_data_o  = rdata_q;
  assign dmi_resp_op_o    = rop_q;
  assign reg_req_o        = (state_q == REQ) & ~rst_i;
  assign reg_we_o         = reg_req_o & (op_q == OP_WRITE);
  assign reg_addr_o       = addr_q;
  assign reg_wdata_o      = data_q;

endmodule

// File: tb/tb_riscv_dmi_target.sv
// Bench for riscv_dmi_target: directed plan steps plus randomized
// transactions checked against a transaction-level expectation model.
module tb_riscv_dmi_target;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dmi_req_valid_i;
  logic        dmi_req_ready_o;
  logic [6:0]  dmi_req_addr_i;
  logic [31:0] dmi_req_data_i;
  logic [1:0]  dmi_req_op_i;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i;
  logic [31:0] dmi_resp_data_o;
  logic [1:0]  dmi_resp_op_o;
  logic        reg_req_o;
  logic        reg_we_o;
  logic [6:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_gnt_i;
  logic        reg_rvalid_i;
  logic [31:0] reg_rdata_i;
  logic        reg_err_i;

  int n_chk  = 0;
  int n_fail = 0;

  riscv_dmi_target #(
    .ADDR_WIDTH(7),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .dmi_req_valid_i(dmi_req_valid_i),
    .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_req_addr_i(dmi_req_addr_i),
    .dmi_req_data_i(dmi_req_data_i),
    .dmi_req_op_i(dmi_req_op_i),
    .dmi_resp_valid_o(dmi_resp_valid_o),
    .dmi_resp_ready_i(dmi_resp_ready_i),
    .dmi_resp_data_o(dmi_resp_data_o),
    .dmi_resp_op_o(dmi_resp_op_o),
    .reg_req_o(reg_req_o),
    .reg_we_o(reg_we_o),
    .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_gnt_i(reg_gnt_i),
    .reg_rvalid_i(reg_rvalid_i),
    .reg_rdata_i(reg_rdata_i),
    .reg_err_i(reg_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One DMI transaction; backend grants in REQ cycle gd, completes rd
  // cycles later; response is held unaccepted for rr cycles.
  task automatic txn(input logic [1:0] op, input logic [6:0] addr,
                     input logic [31:0] wd, input int gd, input int rd,
                     input logic err, input logic [31:0] rdata,
                     input int rr);
    logic [31:0] ed;
    logic [1:0]  eo;
    int ereq, elat, nreq, c;
    bit done;
    ed = 32'h0;
    if (op == 2'd0) begin
      eo = 2'd0; ereq = 0; elat = 0;
    end else if (op == 2'd3) begin
      eo = 2'd2; ereq = 0; elat = 0;
    end else if (gd >= TO) begin
      eo = 2'd2; ereq = TO; elat = TO;
    end else begin
      ereq = gd + 1;
      elat = gd + rd + 1;
      eo   = err ? 2'd2 : 2'd0;
      if (!err && op == 2'd1) ed = rdata;
    end
    c = 0;
    @(negedge clk_i);
    while (!dmi_req_ready_o && c < 50) begin
      @(negedge clk_i);
      c++;
    end
    chk("req_ready_idle", dmi_req_ready_o, 1);
    dmi_req_valid_i = 1'b1;
    dmi_req_op_i    = op;
    dmi_req_addr_i  = addr;
    dmi_req_data_i  = wd;
    @(posedge clk_i);
    #1;
    nreq = 0;
    done = 1'b0;
    for (c = 0; c < 60 && !done; c++) begin
      reg_gnt_i       = (c == gd);
      reg_rvalid_i    = (c == gd + rd);
      reg_rdata_i     = reg_rvalid_i ? rdata : $urandom;
      reg_err_i       = reg_rvalid_i ? err : 1'($urandom);
      dmi_req_valid_i = 1'($urandom);
      dmi_req_op_i    = 2'($urandom);
      dmi_req_addr_i  = 7'($urandom);
      dmi_req_data_i  = $urandom;
      @(negedge clk_i);
      if (dmi_resp_valid_o) begin
        done = 1'b1;
        chk("latency", c, elat);
      end else if (reg_req_o) begin
        nreq++;
        chk("reg_addr", reg_addr_o, addr);
        chk("reg_we", reg_we_o, op == 2'd2);
        chk("reg_wdata", reg_wdata_o, wd);
      end
      if (!done) begin
        @(posedge clk_i);
        #1;
      end
    end
    chk("resp_seen", done, 1);
    reg_gnt_i    = 1'b0;
    reg_rvalid_i = 1'b0;
    chk("req_cycles", nreq, ereq);
    chk("resp_data", dmi_resp_data_o, ed);
    chk("resp_op", dmi_resp_op_o, eo);
    chk("ready_in_resp", dmi_req_ready_o, 0);
    for (int i = 0; i < rr; i++) begin
      @(negedge clk_i);
      chk("hold_valid", dmi_resp_valid_o, 1);
      chk("hold_data", dmi_resp_data_o, ed);
      chk("hold_op", dmi_resp_op_o, eo);
      chk("hold_ready", dmi_req_ready_o, 0);
    end
    dmi_resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    dmi_resp_ready_i = 1'b0;
    dmi_req_valid_i  = 1'b0;
    @(negedge clk_i);
    chk("resp_done", dmi_resp_valid_o, 0);
    chk("ready_after", dmi_req_ready_o, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    int r;
    rst_i            = 1'b1;
    dmi_req_valid_i  = 1'b0;
    dmi_req_addr_i   = '0;
    dmi_req_data_i   = '0;
    dmi_req_op_i     = '0;
    dmi_resp_ready_i = 1'b0;
    reg_gnt_i        = 1'b0;
    reg_rvalid_i     = 1'b0;
    reg_rdata_i      = '0;
    reg_err_i        = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", dmi_req_ready_o, 0);
    chk("rst_resp_valid", dmi_resp_valid_o, 0);
    chk("rst_resp_data", dmi_resp_data_o, 0);
    chk("rst_resp_op", dmi_resp_op_o, 0);
    chk("rst_reg_req", reg_req_o, 0);
    chk("rst_reg_we", reg_we_o, 0);
    chk("rst_reg_addr", reg_addr_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("ready_post_rst", dmi_req_ready_o, 1);

    txn(2'd1, 7'h11, 32'h0, 1, 2, 1'b0, 32'h0040_0C82, 0);
    txn(2'd2, 7'h10, 32'h8000_0001, 0, 0, 1'b0, 32'h1234_5678, 0);
    txn(2'd0, 7'h05, 32'h1111_1111, 0, 0, 1'b0, 32'h0, 0);
    txn(2'd3, 7'h06, 32'h2222_2222, 0, 0, 1'b0, 32'h0, 0);
    txn(2'd1, 7'h20, 32'h0, 99, 0, 1'b0, 32'h5555_5555, 0);

    // Stray completion while idle must not produce a response.
    reg_rvalid_i = 1'b1;
    reg_gnt_i    = 1'b1;
    reg_err_i    = 1'b1;
    @(posedge clk_i);
    #1;
    reg_rvalid_i = 1'b0;
    reg_gnt_i    = 1'b0;
    reg_err_i    = 1'b0;
    @(negedge clk_i);
    chk("stray_resp_valid", dmi_resp_valid_o, 0);
    chk("stray_ready", dmi_req_ready_o, 1);

    txn(2'd2, 7'h21, 32'hCAFE_0003, 3, 1, 1'b0, 32'h0, 1);
    txn(2'd1, 7'h12, 32'h0, 0, 0, 1'b1, 32'hDEAD_BEEF, 5);

    // Reset while waiting for completion.
    dmi_req_valid_i = 1'b1;
    dmi_req_op_i    = 2'd1;
    dmi_req_addr_i  = 7'h22;
    @(posedge clk_i);
    #1;
    dmi_req_valid_i = 1'b0;
    reg_gnt_i       = 1'b1;
    @(posedge clk_i);
    #1;
    reg_gnt_i = 1'b0;
    chk("wait_no_req", reg_req_o, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("rstw_reg_req", reg_req_o, 0);
    chk("rstw_resp_valid", dmi_resp_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rstw_ready", dmi_req_ready_o, 1);

    // Reset while requesting: the request must drop asynchronously.
    dmi_req_valid_i = 1'b1;
    dmi_req_op_i    = 2'd2;
    dmi_req_addr_i  = 7'h23;
    @(posedge clk_i);
    #1;
    dmi_req_valid_i = 1'b0;
    chk("rstq_req_before", reg_req_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rstq_req_async", reg_req_o, 0);
    chk("rstq_we_async", reg_we_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rstq_ready", dmi_req_ready_o, 1);

    txn(2'd1, 7'h33, 32'h0, 2, 1, 1'b0, 32'h0BAD_F00D, 0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) op = 2'd0;
      else if (r == 1) op = 2'd3;
      else if (r < 6) op = 2'd1;
      else op = 2'd2;
      txn(op, 7'($urandom), $urandom, $urandom_range(0, 5),
          $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
          $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
